// File: rtl/instr_exec_regfile_if.sv
// ---------------------------------------------------------------------------
// Module   : instr_exec_regfile_if
// Purpose  : Write/commit/read bundle between an instruction driver and the
//            instr_exec_regfile responder.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_exec_regfile_if #(
   parameter int OP_W   = 32,
   parameter int RES_W  = 64,
   parameter int ADDR_W = 5
);
   localparam int DATA_W = 3 + 2*OP_W + RES_W;

   logic              wr_valid;
   logic              wr_ready;
   logic [2:0]        wr_opcode;
   logic [OP_W-1:0]   wr_op_a;
   logic [OP_W-1:0]   wr_op_b;
   logic [ADDR_W-1:0] wr_addr;
   logic              done;
   logic [ADDR_W-1:0] done_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ovf;

   modport master (
      output wr_valid, wr_opcode, wr_op_a, wr_op_b, wr_addr, rd_addr,
      input  wr_ready, done, done_addr, rd_data, rd_ovf
   );

   modport slave (
      input  wr_valid, wr_opcode, wr_op_a, wr_op_b, wr_addr, rd_addr,
      output wr_ready, done, done_addr, rd_data, rd_ovf
   );
endinterface

`default_nettype wire

// File: rtl/instr_exec_regfile.sv
// ---------------------------------------------------------------------------
// Module   : instr_exec_regfile
// Purpose  : Executes {opcode, op_a, op_b} writes into a result register file
//            with a bit-serial divider; optional overflow flag under the
//            macro IEXEC_OVF_FLAG_EN.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_exec_regfile #(
   parameter int OP_W   = 32,
   parameter int RES_W  = 64,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   instr_exec_regfile_if.slave   bus
);
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int DATA_W = 3 + 2*OP_W + RES_W;
   localparam int CNT_W  = (OP_W > 1) ? $clog2(OP_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

   localparam logic [2:0] OPC_PASSA = 3'd1;
   localparam logic [2:0] OPC_PASSB = 3'd2;
   localparam logic [2:0] OPC_ADD   = 3'd3;
   localparam logic [2:0] OPC_SUB   = 3'd4;
   localparam logic [2:0] OPC_MULT  = 3'd5;
   localparam logic [2:0] OPC_DIV   = 3'd6;
   localparam logic [2:0] OPC_MOD   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXEC   = 2'd1,
      S_DIVIDE = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        opc_q, opc_d;
   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OP_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic [RES_W-1:0]  a_ext, b_ext, q_mag, r_mag, res;
   logic [OP_W:0]     rem_shift;
   logic              we;

   function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
      return v[OP_W-1] ? -v : v;
   endfunction

   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      a_d       = a_q;
      b_d       = b_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      mem_d     = mem_q;
      rd_data_d = mem_q[bus.rd_addr];
      res       = '0;
      we        = 1'b0;
      a_ext     = {{(RES_W-OP_W){a_q[OP_W-1]}}, a_q};
      b_ext     = {{(RES_W-OP_W){b_q[OP_W-1]}}, b_q};
      q_mag     = {{(RES_W-OP_W){1'b0}}, quo_q};
      r_mag     = {{(RES_W-OP_W){1'b0}}, rem_q};
      rem_shift = {rem_q, quo_q[OP_W-1]};

      case (state_q)
         S_IDLE: begin
            if (bus.wr_valid) begin
               opc_d  = bus.wr_opcode;
               a_d    = bus.wr_op_a;
               b_d    = bus.wr_op_b;
               addr_d = bus.wr_addr;
               // Divide-by-zero bypasses the divider and commits 0 via EXEC.
               if ((bus.wr_opcode == OPC_DIV || bus.wr_opcode == OPC_MOD) && bus.wr_op_b != '0) begin
                  rem_d   = '0;
                  quo_d   = mag(bus.wr_op_a);
                  dvs_d   = mag(bus.wr_op_b);
                  cnt_d   = '0;
                  state_d = S_DIVIDE;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            case (opc_q)
               OPC_PASSA: res = a_ext;
               OPC_PASSB: res = b_ext;
               OPC_ADD:   res = a_ext + b_ext;
               OPC_SUB:   res = a_ext - b_ext;
               OPC_MULT:  res = a_ext * b_ext;
               default:   res = '0;
            endcase
            we      = 1'b1;
            state_d = S_IDLE;
         end
         S_DIVIDE: begin
            // quo_q doubles as the dividend shift register: quotient bits enter from the LSB.
            if (rem_shift >= {1'b0, dvs_q}) begin
               rem_d = OP_W'(rem_shift - {1'b0, dvs_q});
               quo_d = {quo_q[OP_W-2:0], 1'b1};
            end else begin
               rem_d = rem_shift[OP_W-1:0];
               quo_d = {quo_q[OP_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_COMMIT;
            end
         end
         default: begin
            if (opc_q == OPC_DIV) begin
               res = (a_q[OP_W-1] ^ b_q[OP_W-1]) ? -q_mag : q_mag;
            end else begin
               res = a_q[OP_W-1] ? -r_mag : r_mag;
            end
            we      = 1'b1;
            state_d = S_IDLE;
         end
      endcase

      if (we) begin
         mem_d[addr_q] = {opc_q, a_q, b_q, res};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         opc_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         opc_q     <= opc_d;
         a_q       <= a_d;
         b_q       <= b_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         mem_q     <= mem_d;
      end
   end

   // Reset during a commit cycle must suppress the done pulse as well as the write.
   assign bus.wr_ready  = (state_q == S_IDLE) && !reset;
   assign bus.done      = (state_q == S_EXEC || state_q == S_COMMIT) && !reset;
   assign bus.done_addr = bus.done ? addr_q : '0;
   assign bus.rd_data   = rd_data_q;

`ifdef IEXEC_OVF_FLAG_EN
   logic ovf_mem_q [DEPTH];
   logic ovf_mem_d [DEPTH];
   logic rd_ovf_q, rd_ovf_d;
   logic ovf;

   always_comb begin
      ovf = 1'b0;
      if (state_q == S_EXEC && (opc_q == OPC_ADD || opc_q == OPC_SUB)) begin
         ovf = (res != {{(RES_W-OP_W){res[OP_W-1]}}, res[OP_W-1:0]});
      end
      if (state_q == S_COMMIT && opc_q == OPC_DIV) begin
         ovf = (a_q == {1'b1, {(OP_W-1){1'b0}}}) && (b_q == '1);
      end
      ovf_mem_d = ovf_mem_q;
      if (we) begin
         ovf_mem_d[addr_q] = ovf;
      end
      rd_ovf_d = ovf_mem_q[bus.rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ovf_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ovf_mem_q[i] <= 1'b0;
         end
      end else begin
         rd_ovf_q  <= rd_ovf_d;
         ovf_mem_q <= ovf_mem_d;
      end
   end

   assign bus.rd_ovf = rd_ovf_q;
`else
   assign bus.rd_ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_exec_regfile.sv
// ---------------------------------------------------------------------------
// Module   : tb_instr_exec_regfile
// Purpose  : Self-checking bench for instr_exec_regfile (table vectors,
//            corner sequences, randomized ops vs. an arithmetic model).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_exec_regfile;
   localparam int OP_W   = 32;
   localparam int RES_W  = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam int DATA_W = 3 + 2*OP_W + RES_W;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_exec_regfile_if #(.OP_W(OP_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) bus ();

   instr_exec_regfile #(.OP_W(OP_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_mem [DEPTH];
   logic              exp_ovf [DEPTH];

   typedef struct {
      logic [2:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  addr;
      longint      res;
      logic        ovf;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic longint model_res(input logic [2:0] opc, input logic signed [31:0] a,
                                        input logic signed [31:0] b);
      longint la, lb;
      la = a;
      lb = b;
      case (opc)
         3'd0:    return 0;
         3'd1:    return la;
         3'd2:    return lb;
         3'd3:    return la + lb;
         3'd4:    return la - lb;
         3'd5:    return la * lb;
         3'd6:    return (lb == 0) ? 0 : la / lb;
         default: return (lb == 0) ? 0 : la % lb;
      endcase
   endfunction

   function automatic logic model_ovf(input logic [2:0] opc, input logic signed [31:0] a,
                                      input logic signed [31:0] b);
      longint r;
      r = model_res(opc, a, b);
      if (opc == 3'd3 || opc == 3'd4) return (r > 64'sd2147483647) || (r < -64'sd2147483648);
      if (opc == 3'd6) return (a == 32'sh80000000) && (b == -32'sd1);
      return 1'b0;
   endfunction

   function automatic logic [31:0] rnd_op();
      int t;
      case ($urandom % 6)
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         3: begin
            t = int'($urandom_range(0, 20)) - 10;
            return t;
         end
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!bus.wr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("ready_timeout", 1'b0, 1'b1);
   endtask

   // Starts and ends on a negedge; junk=1 keeps wr_valid high with garbage while busy.
   task automatic write_check(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] addr, input longint exp_res, input logic exp_o,
                              input bit junk);
      int lat, exp_lat;
      logic [DATA_W-1:0] old_v, new_v;
      logic [RES_W-1:0]  r;
      logic              o_eff;
      r       = exp_res;
      exp_lat = ((opc == 3'd6 || opc == 3'd7) && b != 0) ? OP_W + 1 : 1;
`ifdef IEXEC_OVF_FLAG_EN
      o_eff = exp_o;
`else
      o_eff = 1'b0;
`endif
      wait_ready();
      old_v = exp_mem[addr];
      new_v = {opc, a, b, r};
      bus.wr_valid  = 1'b1;
      bus.wr_opcode = opc;
      bus.wr_op_a   = a;
      bus.wr_op_b   = b;
      bus.wr_addr   = addr;
      bus.rd_addr   = addr;
      @(posedge clk);
      #1;
      bus.wr_valid  = junk;
      bus.wr_opcode = 3'($urandom);
      bus.wr_op_a   = $urandom;
      bus.wr_op_b   = $urandom;
      bus.wr_addr   = addr + 5'd1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!bus.done) chk("busy_ready_low", bus.wr_ready, 1'b0);
      end while (!bus.done && lat < 100);
      chk("done_latency", lat, exp_lat);
      chk("done_addr", bus.done_addr, addr);
      chk("ready_at_done", bus.wr_ready, 1'b0);
      chk("rd_before_commit", bus.rd_data, old_v);
      bus.wr_valid = 1'b0;
      @(negedge clk);
      chk("done_one_pulse", bus.done, 1'b0);
      chk("ready_after_done", bus.wr_ready, 1'b1);
      chk("rd_read_before_write", bus.rd_data, old_v);
      @(negedge clk);
      chk("rd_new_entry", bus.rd_data, new_v);
      chk("rd_ovf", bus.rd_ovf, o_eff);
      exp_mem[addr] = new_v;
      exp_ovf[addr] = exp_o;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  opc;
      logic [31:0] a, b;
      logic [4:0]  addr;
      int          dones;

      vt[0]  = '{3'd3, 32'hFFFF_FFF9, 32'd5,          5'd3,  -2,                    1'b0};
      vt[1]  = '{3'd6, 32'hFFFF_FFF1, 32'd4,          5'd31, -3,                    1'b0};
      vt[2]  = '{3'd7, 32'hFFFF_FFF1, 32'd4,          5'd30, -3,                    1'b0};
      vt[3]  = '{3'd6, 32'd9,         32'd0,          5'd7,  0,                     1'b0};
      vt[4]  = '{3'd7, 32'd9,         32'd0,          5'd8,  0,                     1'b0};
      vt[5]  = '{3'd5, 32'hFFFF_FFFD, 32'd7,          5'd4,  -21,                   1'b0};
      vt[6]  = '{3'd4, 32'd5,         32'd12,         5'd5,  -7,                    1'b0};
      vt[7]  = '{3'd1, 32'hFFFF_FF9C, 32'd3,          5'd6,  -100,                  1'b0};
      vt[8]  = '{3'd2, 32'd1,         32'hFFFF_FFF7,  5'd6,  -9,                    1'b0};
      vt[9]  = '{3'd0, 32'd55,        32'd66,         5'd3,  0,                     1'b0};
      vt[10] = '{3'd3, 32'h7FFF_FFFF, 32'd1,          5'd9,  64'h0000_0000_8000_0000, 1'b1};
      vt[11] = '{3'd4, 32'h8000_0000, 32'd1,          5'd11, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1};
      vt[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  5'd12, 64'h0000_0000_8000_0000, 1'b1};
      vt[13] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF,  5'd13, 0,                     1'b0};
      vt[14] = '{3'd5, 32'h8000_0000, 32'h8000_0000,  5'd14, 64'h4000_0000_0000_0000, 1'b0};
      vt[15] = '{3'd6, 32'd100,       32'hFFFF_FFF9,  5'd15, -14,                   1'b0};
      vt[16] = '{3'd7, 32'hFFFF_FF9C, 32'd7,          5'd17, -2,                    1'b0};

      bus.wr_valid  = 1'b0;
      bus.wr_opcode = '0;
      bus.wr_op_a   = '0;
      bus.wr_op_b   = '0;
      bus.wr_addr   = '0;
      bus.rd_addr   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_mem[i] = '0;
         exp_ovf[i] = 1'b0;
      end

      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_addr = 5'(i);
         @(negedge clk);
         chk("reset_rd_data", bus.rd_data, '0);
         chk("reset_wr_ready", bus.wr_ready, 1'b0);
         chk("reset_done", bus.done, 1'b0);
      end
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_addr = 5'(i);
         @(negedge clk);
         chk("cleared_entry", bus.rd_data, '0);
         chk("cleared_ovf", bus.rd_ovf, 1'b0);
      end

      for (int k = 0; k < 17; k++) begin
         write_check(vt[k].opc, vt[k].a, vt[k].b, vt[k].addr, vt[k].res, vt[k].ovf, (k % 3) == 0);
      end

      // Reset five cycles into a divide aborts it without a commit.
      wait_ready();
      bus.rd_addr   = 5'd10;
      bus.wr_valid  = 1'b1;
      bus.wr_opcode = 3'd6;
      bus.wr_op_a   = 32'd1000;
      bus.wr_op_b   = 32'd3;
      bus.wr_addr   = 5'd10;
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      reset = 1'b1;
      #1;
      chk("abort_ready_in_reset", bus.wr_ready, 1'b0);
      chk("abort_done_in_reset", bus.done, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_mem[i] = '0;
         exp_ovf[i] = 1'b0;
      end
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_no_done", dones, 0);
      chk("abort_entry_zero", bus.rd_data, '0);
      write_check(3'd3, 32'd20, 32'd22, 5'd10, 42, 1'b0, 1'b0);

      for (int n = 0; n < 120; n++) begin
         opc  = 3'($urandom_range(0, 7));
         a    = rnd_op();
         b    = rnd_op();
         if ((opc == 3'd6 || opc == 3'd7) && ($urandom % 5) == 0) b = '0;
         addr = 5'($urandom);
         write_check(opc, a, b, addr, model_res(opc, a, b), model_ovf(opc, a, b), ($urandom % 2) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
